// File: rtl/rv_decode_stage.sv
// rv_decode_stage
//   Registered RV32I decode stage sitting between instruction fetch and
//   execute. One instruction is decoded per cycle into register indices,
//   a sign-extended immediate, a format code and control flags. Illegal
//   encodings are flagged and counted in a saturating counter.
//
// Parameters
//   NUM_REGS  : 32 (RV32I) or 16 (RV32E); used indices >= NUM_REGS are illegal
//   ENABLE_M  : 1 makes OP with funct7=0000001 legal (all funct3)
//   ILL_CNT_W : width of the illegal-instruction counter
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous pipeline flush (drops output and any
//                         same-cycle accept)
//   in_valid/in_ready   : fetch-side handshake, in_instr/in_pc payload
//   out_valid/out_ready : execute-side handshake
//   out_*               : registered decode bundle
//   ill_count           : saturating count of accepted illegal instructions
module rv_decode_stage #(
  parameter int NUM_REGS  = 32,
  parameter int ENABLE_M  = 0,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [31:0]          out_imm,
  output logic [2:0]           out_funct3,
  output logic                 out_funct7b5,
  output logic [2:0]           out_fmt,
  output logic                 out_rd_we,
  output logic                 out_uses_rs1,
  output logic                 out_uses_rs2,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7b5;
    fmt_e        fmt;
    logic        rd_we;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        illegal;
  } bundle_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  function automatic logic reg_ok(input logic [4:0] idx);
    return ({1'b0, idx} < NREGS);
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
    return (&v) ? v : v + ILL_CNT_W'(1);
  endfunction

  function automatic logic signed [31:0] imm_gen(input logic [31:0] i, input fmt_e f);
    logic signed [31:0] imm;
    case (f)
      FMT_I:   imm = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm = {i[31:12], 12'b0};
      FMT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  logic [6:0] opcode;
  logic [4:0] f_rd, f_rs1, f_rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = in_instr[6:0];
  assign f_rd   = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];
  assign f7     = in_instr[31:25];

  logic    enc_legal;
  logic    is_fence;
  fmt_e    dec_fmt;
  logic    rd_used, rs1_used, rs2_used;
  logic    idx_ok;
  logic    dec_illegal;
  bundle_t dec;

  // Opcode/funct legality and format selection.
  always_comb begin
    enc_legal = 1'b0;
    is_fence  = 1'b0;
    dec_fmt   = FMT_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        enc_legal = 1'b1;
        dec_fmt   = FMT_U;
      end
      OPC_JAL: begin
        enc_legal = 1'b1;
        dec_fmt   = FMT_J;
      end
      OPC_JALR: begin
        enc_legal = (f3 == 3'b000);
        dec_fmt   = FMT_I;
      end
      OPC_BRANCH: begin
        enc_legal = (f3 != 3'b010) && (f3 != 3'b011);
        dec_fmt   = FMT_B;
      end
      OPC_LOAD: begin
        enc_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        dec_fmt   = FMT_I;
      end
      OPC_STORE: begin
        enc_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        dec_fmt   = FMT_S;
      end
      OPC_OPIMM: begin
        dec_fmt = FMT_I;
        case (f3)
          3'b001:  enc_legal = (f7 == 7'b0000000);
          3'b101:  enc_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: enc_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec_fmt   = FMT_R;
        enc_legal = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                    ((f7 == 7'b0000001) && (ENABLE_M != 0));
      end
      OPC_MISC: begin
        enc_legal = 1'b1;
        is_fence  = 1'b1;
        dec_fmt   = FMT_I;
      end
      OPC_SYSTEM: begin
        // Only ECALL and EBREAK; no register use.
        enc_legal = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
        dec_fmt   = FMT_NONE;
      end
      default: begin
        enc_legal = 1'b0;
        dec_fmt   = FMT_NONE;
      end
    endcase
  end

  assign rs1_used = (dec_fmt == FMT_R) || (dec_fmt == FMT_I) ||
                    (dec_fmt == FMT_S) || (dec_fmt == FMT_B);
  assign rs2_used = (dec_fmt == FMT_R) || (dec_fmt == FMT_S) || (dec_fmt == FMT_B);
  assign rd_used  = ((dec_fmt == FMT_R) || (dec_fmt == FMT_I) ||
                     (dec_fmt == FMT_U) || (dec_fmt == FMT_J)) && !is_fence;

  assign idx_ok = (!rd_used  || reg_ok(f_rd))  &&
                  (!rs1_used || reg_ok(f_rs1)) &&
                  (!rs2_used || reg_ok(f_rs2));

  assign dec_illegal = !(enc_legal && idx_ok);

  // Illegal instructions collapse to an all-zero NONE bundle; pc and the raw
  // funct fields still pass through.
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.funct3   = f3;
    dec.funct7b5 = in_instr[30];
    dec.fmt      = FMT_NONE;
    dec.illegal  = dec_illegal;
    if (!dec_illegal) begin
      dec.fmt      = dec_fmt;
      dec.rd       = rd_used  ? f_rd  : 5'd0;
      dec.rs1      = rs1_used ? f_rs1 : 5'd0;
      dec.rs2      = rs2_used ? f_rs2 : 5'd0;
      dec.imm      = imm_gen(in_instr, dec_fmt);
      dec.rd_we    = rd_used && (f_rd != 5'd0);
      dec.uses_rs1 = rs1_used;
      dec.uses_rs2 = rs2_used;
    end
  end

  logic                 out_valid_d, out_valid_q;
  bundle_t              bundle_d, bundle_q;
  logic [ILL_CNT_W-1:0] ill_count_d, ill_count_q;
  logic                 accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    ill_count_d = ill_count_q;
    if (flush) begin
      // A same-cycle accept is dropped and never counted.
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
      if (dec_illegal) ill_count_d = sat_inc(ill_count_q);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---- decode -> execute register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      ill_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      ill_count_q <= ill_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = bundle_q.pc;
  assign out_rd       = bundle_q.rd;
  assign out_rs1      = bundle_q.rs1;
  assign out_rs2      = bundle_q.rs2;
  assign out_imm      = bundle_q.imm;
  assign out_funct3   = bundle_q.funct3;
  assign out_funct7b5 = bundle_q.funct7b5;
  assign out_fmt      = bundle_q.fmt;
  assign out_rd_we    = bundle_q.rd_we;
  assign out_uses_rs1 = bundle_q.uses_rs1;
  assign out_uses_rs2 = bundle_q.uses_rs2;
  assign out_illegal  = bundle_q.illegal;
  assign ill_count    = ill_count_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  always #5 clk = ~clk;

  // Instance A: RV32I, no M, 8-bit counter
  logic a_in_ready, a_out_valid, a_funct7b5, a_rd_we, a_uses_rs1, a_uses_rs2, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [2:0] a_funct3, a_fmt;
  logic [7:0] a_cnt;

  // Instance B: RV32E, M enabled, 2-bit counter
  logic b_in_ready, b_out_valid, b_funct7b5, b_rd_we, b_uses_rs1, b_uses_rs2, b_illegal;
  logic [31:0] b_pc, b_imm;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [2:0] b_funct3, b_fmt;
  logic [1:0] b_cnt;

  rv_decode_stage #(.NUM_REGS(32), .ENABLE_M(0), .ILL_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm),
    .out_funct3(a_funct3), .out_funct7b5(a_funct7b5), .out_fmt(a_fmt), .out_rd_we(a_rd_we),
    .out_uses_rs1(a_uses_rs1), .out_uses_rs2(a_uses_rs2), .out_illegal(a_illegal),
    .ill_count(a_cnt));

  rv_decode_stage #(.NUM_REGS(16), .ENABLE_M(1), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm),
    .out_funct3(b_funct3), .out_funct7b5(b_funct7b5), .out_fmt(b_fmt), .out_rd_we(b_rd_we),
    .out_uses_rs1(b_uses_rs1), .out_uses_rs2(b_uses_rs2), .out_illegal(b_illegal),
    .ill_count(b_cnt));

  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0;
    #2;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_out_valid); end
    total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    total++; if (a_imm !== 32'h0 || a_pc !== 32'h0 || a_rd !== 5'd0) begin bad++; $display("FAIL reset_payload imm=%h pc=%h rd=%0d exp=0", a_imm, a_pc, a_rd); end
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", a_out_valid); end
    total++; if (a_fmt !== 3'd1 || a_rd !== 5'd1 || a_rs1 !== 5'd0) begin bad++; $display("FAIL addi_fields fmt=%0d rd=%0d rs1=%0d exp=1/1/0", a_fmt, a_rd, a_rs1); end
    total++; if (a_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffff", a_imm); end
    total++; if (a_rd_we !== 1'b1 || a_uses_rs1 !== 1'b1 || a_uses_rs2 !== 1'b0 || a_illegal !== 1'b0) begin bad++; $display("FAIL addi_flags we=%b r1=%b r2=%b ill=%b exp=1100", a_rd_we, a_uses_rs1, a_uses_rs2, a_illegal); end
    total++; if (a_pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%h exp=100", a_pc); end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h200; out_ready = 1'b1;
    step();
    in_instr = 32'hFE000EE3; in_pc = 32'h204;
    total++; if (a_out_valid !== 1'b1 || a_fmt !== 3'd2 || a_imm !== 32'd8) begin bad++; $display("FAIL sw_fmt_imm v=%b fmt=%0d imm=%h exp=1/2/8", a_out_valid, a_fmt, a_imm); end
    total++; if (a_rs1 !== 5'd1 || a_rs2 !== 5'd2 || a_rd !== 5'd0 || a_rd_we !== 1'b0) begin bad++; $display("FAIL sw_regs rs1=%0d rs2=%0d rd=%0d we=%b exp=1/2/0/0", a_rs1, a_rs2, a_rd, a_rd_we); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", a_in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_fmt !== 3'd3 || a_imm !== 32'hFFFFFFFC || a_pc !== 32'h204) begin bad++; $display("FAIL beq v=%b fmt=%0d imm=%h pc=%h exp=1/3/fffffffc/204", a_out_valid, a_fmt, a_imm, a_pc); end
    step();
  endtask

  task automatic test_mul();
    in_valid = 1'b1; in_instr = 32'h022081B3; in_pc = 32'h300; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (a_illegal !== 1'b1 || a_fmt !== 3'd6 || a_rd !== 5'd0 || a_rd_we !== 1'b0) begin bad++; $display("FAIL mul_nom ill=%b fmt=%0d rd=%0d we=%b exp=1/6/0/0", a_illegal, a_fmt, a_rd, a_rd_we); end
    total++; if (a_cnt !== 8'd1 || a_pc !== 32'h300) begin bad++; $display("FAIL mul_nom_cnt cnt=%0d pc=%h exp=1/300", a_cnt, a_pc); end
    total++; if (b_illegal !== 1'b0 || b_fmt !== 3'd0 || b_rd !== 5'd3 || b_rd_we !== 1'b1) begin bad++; $display("FAIL mul_m ill=%b fmt=%0d rd=%0d we=%b exp=0/0/3/1", b_illegal, b_fmt, b_rd, b_rd_we); end
    step();
  endtask

  task automatic test_rv32e();
    in_valid = 1'b1; in_instr = 32'h00208833; out_ready = 1'b1;
    step();
    in_instr = 32'h002087B3;
    total++; if (b_illegal !== 1'b1 || b_rd_we !== 1'b0 || b_fmt !== 3'd6 || b_cnt !== 2'd1) begin bad++; $display("FAIL e_x16 ill=%b we=%b fmt=%0d cnt=%0d exp=1/0/6/1", b_illegal, b_rd_we, b_fmt, b_cnt); end
    total++; if (a_illegal !== 1'b0 || a_rd !== 5'd16 || a_rd_we !== 1'b1) begin bad++; $display("FAIL i_x16 ill=%b rd=%0d we=%b exp=0/16/1", a_illegal, a_rd, a_rd_we); end
    step();
    in_valid = 1'b0;
    total++; if (b_illegal !== 1'b0 || b_rd !== 5'd15 || b_rd_we !== 1'b1 || b_cnt !== 2'd1) begin bad++; $display("FAIL e_x15 ill=%b rd=%0d we=%b cnt=%0d exp=0/15/1/1", b_illegal, b_rd, b_rd_we, b_cnt); end
    step();
  endtask

  task automatic test_misc_formats();
    in_valid = 1'b1; in_instr = 32'h008000EF; out_ready = 1'b1;
    step();
    in_instr = 32'h12345137;
    total++; if (a_fmt !== 3'd5 || a_imm !== 32'd8 || a_rd !== 5'd1 || a_uses_rs1 !== 1'b0) begin bad++; $display("FAIL jal fmt=%0d imm=%h rd=%0d r1=%b exp=5/8/1/0", a_fmt, a_imm, a_rd, a_uses_rs1); end
    step();
    in_instr = 32'h00000073;
    total++; if (a_fmt !== 3'd4 || a_imm !== 32'h12345000 || a_rd !== 5'd2 || a_rd_we !== 1'b1) begin bad++; $display("FAIL lui fmt=%0d imm=%h rd=%0d we=%b exp=4/12345000/2/1", a_fmt, a_imm, a_rd, a_rd_we); end
    step();
    in_valid = 1'b0;
    total++; if (a_fmt !== 3'd6 || a_illegal !== 1'b0 || a_rd_we !== 1'b0 || a_uses_rs1 !== 1'b0 || a_uses_rs2 !== 1'b0) begin bad++; $display("FAIL ecall fmt=%0d ill=%b we=%b r1=%b r2=%b exp=6/0/0/0/0", a_fmt, a_illegal, a_rd_we, a_uses_rs1, a_uses_rs2); end
    step();
  endtask

  task automatic test_stall_flush();
    in_valid = 1'b1; in_instr = 32'h00700293; out_ready = 1'b0;
    step();
    in_instr = 32'h0020A423;
    for (int i = 0; i < 3; i++) begin
      total++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_imm !== 32'd7 || a_rd !== 5'd5) begin bad++; $display("FAIL stall%0d rdy=%b v=%b imm=%h rd=%0d exp=0/1/7/5", i, a_in_ready, a_out_valid, a_imm, a_rd); end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL unstall_ready got=%b exp=1", a_in_ready); end
    step();
    total++; if (a_out_valid !== 1'b1 || a_fmt !== 3'd2) begin bad++; $display("FAIL unstall_sw v=%b fmt=%0d exp=1/2", a_out_valid, a_fmt); end
    flush = 1'b1; in_instr = 32'h00000000;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b0 || a_cnt !== 8'd1) begin bad++; $display("FAIL flush v=%b cnt=%0d exp=0/1", a_out_valid, a_cnt); end
    step();
  endtask

  task automatic test_saturate_reset();
    logic [1:0] exp_b [5];
    exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3; exp_b[3] = 2'd3; exp_b[4] = 2'd3;
    rst_n = 1'b0;
    #2;
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00000000; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (b_cnt !== exp_b[i] || a_cnt !== 8'(i + 1)) begin bad++; $display("FAIL sat%0d b=%0d a=%0d exp=%0d/%0d", i, b_cnt, a_cnt, exp_b[i], i + 1); end
    end
    rst_n = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_cnt !== 8'd0 || b_cnt !== 2'd0 || b_out_valid !== 1'b0) begin bad++; $display("FAIL midreset av=%b ac=%0d bv=%b bc=%0d exp=0", a_out_valid, a_cnt, b_out_valid, b_cnt); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_mul();
    test_rv32e();
    test_misc_formats();
    test_stall_flush();
    test_saturate_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
